// File: rtl/rnd_replay_chk.sv
// Replay checker: drives a random vector generator through init/save/run/restore/replay
// and compares fold signatures of both runs. Optional looping: RND_REPLAY_CHK_LOOP_EN.
module rnd_replay_chk #(
  parameter int RUN_LEN = 1024,
  parameter int SIG_W   = 32
) (
  input  logic             clk50,
  input  logic             rst_n,
  input  logic             start,
  input  logic [74:0]      rnd_out,
  output logic             rnd_init,
  output logic             rnd_save,
  output logic             rnd_restore,
  output logic             rnd_next,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig
`ifdef RND_REPLAY_CHK_LOOP_EN
  ,
  output logic [15:0]      loop_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SAVE, S_RUN_A, S_RESTORE, S_RUN_B, S_CMP, S_DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(RUN_LEN - 1);

  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [SIG_W-1:0] r_acc;
  logic [SIG_W-1:0] r_sig_a;
  logic [SIG_W-1:0] r_sig;
  logic             r_init, r_save, r_restore, r_next;
  logic             r_busy, r_done, r_pass;
  logic             r_cap;
`ifdef RND_REPLAY_CHK_LOOP_EN
  logic [15:0]      r_loop;
`endif

  logic [SIG_W-1:0] w_mix;
  logic [SIG_W-1:0] w_fold;
  logic             w_match;

  assign w_mix   = rnd_out[31:0] ^ rnd_out[63:32] ^ {21'b0, rnd_out[74:64]};
  assign w_fold  = {r_acc[SIG_W-2:0], r_acc[SIG_W-1]} ^ w_mix;
  // The final run-B capture lands in the CMP cycle, so compare against the folded value.
  assign w_match = (w_fold == r_sig_a);

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_sig_a   <= '0;
      r_sig     <= '0;
      r_init    <= 1'b0;
      r_save    <= 1'b0;
      r_restore <= 1'b0;
      r_next    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_cap     <= 1'b0;
`ifdef RND_REPLAY_CHK_LOOP_EN
      r_loop    <= '0;
`endif
    end else begin
      r_init    <= 1'b0;
      r_save    <= 1'b0;
      r_restore <= 1'b0;
      r_next    <= 1'b0;
      r_cap     <= r_next;
      if (r_cap) r_acc <= w_fold;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_INIT;
            r_init  <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
`ifdef RND_REPLAY_CHK_LOOP_EN
            r_loop  <= '0;
`endif
          end
        end
        S_INIT: begin
          r_state <= S_SAVE;
          r_save  <= 1'b1;
        end
        S_SAVE: begin
          r_state <= S_RUN_A;
          r_next  <= 1'b1;
          r_cnt   <= '0;
          r_acc   <= '0;
        end
        S_RUN_A: begin
          if (r_cnt == LAST) begin
            r_state   <= S_RESTORE;
            r_restore <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_next <= 1'b1;
          end
        end
        S_RESTORE: begin
          // Last run-A capture happens here; it goes to sig_a while acc restarts for run B.
          r_state <= S_RUN_B;
          r_next  <= 1'b1;
          r_cnt   <= '0;
          r_acc   <= '0;
          r_sig_a <= w_fold;
        end
        S_RUN_B: begin
          if (r_cnt == LAST) begin
            r_state <= S_CMP;
          end else begin
            r_cnt  <= r_cnt + 16'd1;
            r_next <= 1'b1;
          end
        end
        S_CMP: begin
          r_pass <= w_match;
          r_sig  <= r_sig_a;
`ifdef RND_REPLAY_CHK_LOOP_EN
          if (w_match) begin
            r_state <= S_SAVE;
            r_save  <= 1'b1;
            if (r_loop != 16'hFFFF) r_loop <= r_loop + 16'd1;
          end else begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
`else
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rnd_init    = r_init;
  assign rnd_save    = r_save;
  assign rnd_restore = r_restore;
  assign rnd_next    = r_next;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign sig         = r_sig;
`ifdef RND_REPLAY_CHK_LOOP_EN
  assign loop_cnt    = r_loop;
`endif

endmodule

// File: tb/tb_rnd_replay_chk.sv
// Directed bench for rnd_replay_chk: one RUN_LEN=4 instance with a corruptible
// generator model and one RUN_LEN=1 instance with an ideal generator.
module tb_rnd_replay_chk;

  localparam logic [74:0] SEED = 75'h2A5_DEAD_BEEF_CAFE_F00D;
  localparam logic [74:0] INC  = 75'h1_3579_BDF0_2468_ACE1;
  localparam logic [74:0] BIT70 = 75'd1 << 70;

  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic rst_n = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0;
  int   checks = 0, failures = 0;
  int   corrupt_at = 0;

  logic [74:0] g4_s = '0, g4_sv = '0, g1_s = '0, g1_sv = '0;
  int   g4_b = 0, g4_r = 0;
  logic [74:0] rnd_out4, rnd_out1;

  logic init4, save4, restore4, next4, busy4, done4, pass4;
  logic init1, save1, restore1, next1, busy1, done1, pass1;
  logic [31:0] sig4, sig1;
`ifdef RND_REPLAY_CHK_LOOP_EN
  logic [15:0] loop_cnt4, loop_cnt1;
`endif

  rnd_replay_chk #(.RUN_LEN(4), .SIG_W(32)) dut4 (
    .clk50(clk50), .rst_n(rst_n), .start(start4), .rnd_out(rnd_out4),
    .rnd_init(init4), .rnd_save(save4), .rnd_restore(restore4), .rnd_next(next4),
    .busy(busy4), .done(done4), .pass(pass4), .sig(sig4)
`ifdef RND_REPLAY_CHK_LOOP_EN
    , .loop_cnt(loop_cnt4)
`endif
  );

  rnd_replay_chk #(.RUN_LEN(1), .SIG_W(32)) dut1 (
    .clk50(clk50), .rst_n(rst_n), .start(start1), .rnd_out(rnd_out1),
    .rnd_init(init1), .rnd_save(save1), .rnd_restore(restore1), .rnd_next(next1),
    .busy(busy1), .done(done1), .pass(pass1), .sig(sig1)
`ifdef RND_REPLAY_CHK_LOOP_EN
    , .loop_cnt(loop_cnt1)
`endif
  );

  // Ideal generator: state advances by INC per next; g4_b counts vectors since restore.
  always @(posedge clk50) begin
    if (init4) begin
      g4_s <= SEED;
      g4_r <= 0;
    end else if (save4) begin
      g4_sv <= g4_s;
    end else if (restore4) begin
      g4_s <= g4_sv;
      g4_r <= g4_r + 1;
      g4_b <= 0;
    end else if (next4) begin
      g4_s <= g4_s + INC;
      g4_b <= g4_b + 1;
    end
  end
  assign rnd_out4 = g4_s ^ ((corrupt_at != 0 && g4_r == corrupt_at && g4_b == 3) ? BIT70 : 75'd0);

  always @(posedge clk50) begin
    if (init1)         g1_s  <= SEED;
    else if (save1)    g1_sv <= g1_s;
    else if (restore1) g1_s  <= g1_sv;
    else if (next1)    g1_s  <= g1_s + INC;
  end
  assign rnd_out1 = g1_s;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy,done,init,save,restore,next} expected c cycles after start was sampled.
  function automatic logic [5:0] exp_ctl(input int c, input int L);
    logic b, d, i, s, r, n;
    i = (c == 1);
    s = (c == 2);
    n = (c >= 3 && c <= 2 + L) || (c >= 4 + L && c <= 3 + 2 * L);
    r = (c == 3 + L);
    b = (c >= 1 && c <= 4 + 2 * L);
    d = (c == 5 + 2 * L);
    return {b, d, i, s, r, n};
  endfunction

  // Fold signature of four consecutive vectors SEED+INC*(k0+1..k0+4).
  function automatic logic [31:0] exp_sig(input int k0);
    logic [31:0] a;
    logic [74:0] v;
    a = '0;
    for (int k = 1; k <= 4; k++) begin
      v = SEED + INC * 75'(k0 + k);
      a = {a[30:0], a[31]} ^ v[31:0] ^ v[63:32] ^ {21'b0, v[74:64]};
    end
    return a;
  endfunction

  task automatic run4(input string tag, input int glitch_c);
    int ni, ns, nr, nn, nd;
    ni = 0; ns = 0; nr = 0; nn = 0; nd = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("%s ctl c=%0d", tag, c),
          {busy4, done4, init4, save4, restore4, next4}, exp_ctl(c, 4));
      ni += int'(init4); ns += int'(save4); nr += int'(restore4);
      nn += int'(next4); nd += int'(done4);
      start4 = (c == glitch_c);
      if (c < 13) tick();
    end
    start4 = 1'b0;
    chk({tag, " pulses"}, {8'(ni), 8'(ns), 8'(nr), 8'(nn), 8'(nd)}, {8'd1, 8'd1, 8'd1, 8'd8, 8'd1});
  endtask

  initial begin
    tick(); tick(); tick();
    chk("reset dut4", {busy4, done4, init4, save4, restore4, next4, pass4, sig4}, '0);
    chk("reset dut1", {busy1, done1, init1, save1, restore1, next1, pass1, sig1}, '0);
    rst_n = 1'b1;
    tick();

`ifdef RND_REPLAY_CHK_LOOP_EN
    chk("reset loop_cnt", loop_cnt4, 16'd0);
    corrupt_at = 4;
    begin
      int n;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 300) begin
        tick();
        n++;
      end
      chk("loop done seen", done4, 1'b1);
      chk("loop loop_cnt", loop_cnt4, 16'd3);
      chk("loop pass", pass4, 1'b0);
      chk("loop sig", sig4, exp_sig(12));
    end
`else
    run4("good", 0);
    chk("good pass", pass4, 1'b1);
    chk("good sig", sig4, exp_sig(0));
    tick();
    chk("done holds", {busy4, done4}, 2'b01);

    corrupt_at = 1;
    run4("corrupt", 0);
    chk("corrupt pass", pass4, 1'b0);
    chk("corrupt sig", sig4, exp_sig(0));
    corrupt_at = 0;

    run4("glitch", 4);
    chk("glitch pass", pass4, 1'b1);

    // Reset asserted during the second RUN_B cycle (cycle 9 after start).
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int c = 2; c <= 9; c++) tick();
    chk("pre-reset next", {busy4, next4}, 2'b11);
    rst_n = 1'b0;
    tick();
    chk("midrun reset", {busy4, done4, init4, save4, restore4, next4, pass4, sig4}, '0);
    rst_n = 1'b1;
    begin
      int act;
      act = 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        act += int'(busy4 | done4 | init4 | save4 | restore4 | next4);
      end
      chk("post-reset idle", 32'(act), 32'd0);
    end

    // RUN_LEN=1 with start held: 7-cycle period, DONE for one cycle then INIT again.
    start1 = 1'b1;
    tick();
    for (int it = 0; it < 2; it++) begin
      for (int c = 1; c <= 7; c++) begin
        chk($sformatf("len1 it=%0d ctl c=%0d", it, c),
            {busy1, done1, init1, save1, restore1, next1}, exp_ctl(c, 1));
        if (c == 7) chk($sformatf("len1 it=%0d pass", it), pass1, 1'b1);
        tick();
      end
    end
    chk("len1 reinit", {busy1, done1, init1}, 3'b101);
    start1 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rnd_replay_chk.md
RND_REPLAY_CHK -- requirements
Module: rnd_replay_chk

Interface
REQ-001 The module SHALL have parameter RUN_LEN, default 1024: number of rnd_next cycles per run, legal range 1..65535.
REQ-002 The module SHALL have parameter SIG_W, default 32: signature width, fixed at 32 in this revision.
REQ-003 The module SHALL have port clk50  in  1  sole clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n  in  1  synchronous, active-low reset.
REQ-005 The module SHALL have port start  in  1  level/pulse; sampled high in IDLE or DONE starts a check.
REQ-006 The module SHALL have port rnd_out  in  75  vector from the upstream random vector generator.
REQ-007 The module SHALL have ports rnd_init, rnd_save, rnd_restore, rnd_next  out  1 each  registered controls to the generator.
REQ-008 The module SHALL have port busy  out  1  high in every state other than IDLE and DONE.
REQ-009 The module SHALL have port done  out  1  high only in DONE.
REQ-010 The module SHALL have port pass  out  1  valid while done; 1 means the replay signature matched.
REQ-011 The module SHALL have port sig  out  32  last completed run-A signature, held until the next CMP.

Function
REQ-012 The FSM SHALL have the states IDLE, INIT, SAVE, RUN_A, RESTORE, RUN_B, CMP and DONE.
REQ-013 Transitions SHALL be:
- IDLE->INIT on start.
- INIT->SAVE, SAVE->RUN_A and RESTORE->RUN_B unconditionally, one cycle each.
- RUN_A->RESTORE and RUN_B->CMP when the run counter reaches RUN_LEN-1.
- CMP->DONE unconditionally.
- DONE->INIT on start.
REQ-014 rnd_init SHALL be high exactly during INIT, rnd_save exactly during SAVE, and rnd_restore exactly during RESTORE; the three are mutually exclusive.
REQ-015 rnd_next SHALL be high for exactly RUN_LEN consecutive cycles in each of RUN_A and RUN_B, and low elsewhere.
REQ-016 The generator produces a new rnd_out one cycle after rnd_next is sampled high; a capture strobe SHALL be rnd_next delayed one cycle, giving exactly RUN_LEN captures per run.
REQ-017 The per-run accumulator SHALL be cleared to 0 on entry to RUN_A and on entry to RUN_B.
REQ-018 On each capture, the accumulator SHALL update as acc <= rotl1(acc) ^ (rnd_out[31:0] ^ rnd_out[63:32] ^ {21'b0, rnd_out[74:64]}); arithmetic is modulo 2^32.
REQ-019 On the last capture of run A (the cycle after leaving RUN_A), the accumulator SHALL be copied to sig_a; the last capture of run B is complete before CMP.
REQ-020 In CMP, pass SHALL be registered as (acc == sig_a), sig SHALL be updated to sig_a, and both SHALL be visible from the first DONE cycle.
REQ-021 The run counter SHALL be 16 bits, SHALL be cleared on each run entry, and SHALL never wrap within a run.
REQ-022 start asserted in any state other than IDLE or DONE SHALL be ignored.
REQ-023 With RUN_LEN=1, each run SHALL last one cycle and produce one capture.
REQ-024 If start is high continuously, DONE SHALL last exactly one cycle before re-entering INIT.

Reset
REQ-025 With rst_n low at a clock edge, the FSM SHALL go to IDLE and counter, acc and sig_a SHALL clear.
REQ-026 During reset, rnd_init, rnd_save, rnd_restore, rnd_next, busy, done and pass SHALL be 0, and sig SHALL be 0.
REQ-027 A reset mid-run SHALL abort immediately, with no further control pulses and no DONE.
REQ-028 The first start after reset SHALL begin with INIT.

Configuration
REQ-029 The feature macro SHALL be RND_REPLAY_CHK_LOOP_EN.
REQ-030 With RND_REPLAY_CHK_LOOP_EN defined:
- CMP SHALL go to SAVE rather than DONE whenever pass computes 1, repeating indefinitely without start.
- A 16-bit saturating output port loop_cnt SHALL increment per passing loop.
- The first mismatch SHALL go to DONE with pass=0.
REQ-031 With RND_REPLAY_CHK_LOOP_EN not defined, port loop_cnt SHALL not exist and CMP SHALL always go to DONE.

Verification
REQ-032 Reset, then one start pulse, RUN_LEN=4, with an ideal generator model -> control sequence init, save, 4x next, restore, 4x next; done high 13 cycles after start is sampled; pass=1.
REQ-033 Model corrupts bit 70 on the 3rd replay vector -> pass=0; sig equals the run-A fold signature computed by the bench.
REQ-034 rst_n low during cycle 2 of RUN_B -> all outputs 0 on the next edge; IDLE; no done.
REQ-035 RUN_LEN=1 with start held high -> exactly 1 next per run; done pulses for 1 cycle, then init repeats.
REQ-036 start pulsed during RUN_A -> ignored; pulse counts unchanged.
REQ-037 With RND_REPLAY_CHK_LOOP_EN and a good model for 3 loops, then a mismatch -> loop_cnt=3; done; pass=0.
